// File: rtl/btn_enable_gen_if.sv
// Button-side signal bundle for btn_enable_gen: raw button in, strobe and
// debounced level out.
interface btn_enable_gen_if;
    logic btn;
    logic E;
    logic held;

    modport master (output btn, input E, input held);
    modport slave  (input btn, output E, output held);
endinterface

// File: rtl/btn_enable_gen.sv
// btn_enable_gen: synchronises and debounces a raw push-button, emits a
// one-cycle enable strobe per accepted press, optional hold-to-repeat strobes,
// and exports the debounced button level.
module btn_enable_gen #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned RPT_EN     = 1,
    parameter int unsigned RPT_DELAY  = 64,
    parameter int unsigned RPT_PERIOD = 16,
    parameter int unsigned CW         = 16
) (
    input  logic            clk,
    input  logic            reset,
    btn_enable_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(RPT_PERIOD - 1);

    logic          s1, s2, btn_s;
    state_t        state, state_nxt;
    logic [CW-1:0] dcnt, dcnt_nxt;
    logic [CW-1:0] rcnt, rcnt_nxt;
    logic          rpt_phase, rpt_phase_nxt;
    logic          e_q, e_nxt;
    logic          held_q, held_nxt;

    assign btn_s    = s2;
    assign bus.E    = e_q;
    assign bus.held = held_q;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.btn;
            s2 <= s1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dcnt      <= '0;
            rcnt      <= '0;
            rpt_phase <= 1'b0;
            e_q       <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            dcnt      <= dcnt_nxt;
            rcnt      <= rcnt_nxt;
            rpt_phase <= rpt_phase_nxt;
            e_q       <= e_nxt;
            held_q    <= held_nxt;
        end
    end

    // Next-state, debounce/repeat counting and strobe generation.
    // rpt_phase selects the first-repeat delay (0) or the steady period (1);
    // rcnt restarts at each strobe so both intervals count from zero.
    always_comb begin
        state_nxt     = state;
        dcnt_nxt      = dcnt;
        rcnt_nxt      = rcnt;
        rpt_phase_nxt = rpt_phase;
        e_nxt         = 1'b0;
        held_nxt      = held_q;
        case (state)
            IDLE: begin
                held_nxt = 1'b0;
                if (btn_s) begin
                    state_nxt = PRESS_DB;
                    dcnt_nxt  = ONE;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = '0;
                end else if (dcnt == DEB_LAST) begin
                    state_nxt     = HELD;
                    e_nxt         = 1'b1;
                    held_nxt      = 1'b1;
                    dcnt_nxt      = '0;
                    rcnt_nxt      = '0;
                    rpt_phase_nxt = 1'b0;
                end else begin
                    dcnt_nxt = dcnt + ONE;
                end
            end
            HELD: begin
                held_nxt = 1'b1;
                if (!btn_s) begin
                    state_nxt = RELEASE_DB;
                    dcnt_nxt  = ONE;
                    rcnt_nxt  = '0;
                end else if (RPT_EN != 0) begin
                    if (rcnt == (rpt_phase ? PER_LAST : DLY_LAST)) begin
                        e_nxt         = 1'b1;
                        rcnt_nxt      = '0;
                        rpt_phase_nxt = 1'b1;
                    end else begin
                        rcnt_nxt = rcnt + ONE;
                    end
                end
            end
            RELEASE_DB: begin
                if (btn_s) begin
                    state_nxt     = HELD;
                    dcnt_nxt      = '0;
                    rcnt_nxt      = '0;
                    rpt_phase_nxt = 1'b0;
                end else if (dcnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    held_nxt  = 1'b0;
                    dcnt_nxt  = '0;
                end else begin
                    dcnt_nxt = dcnt + ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
